// File: rtl/meter_pkg.sv
// Shared definitions for the band meter sequencer.
//  - default bank geometry and scaling constants
//  - sequencer state encoding
//  - band-index width helper
package meter_pkg;

  localparam int DEF_NUM_BANDS   = 7;
  localparam int DEF_PW          = 11;
  localparam int DEF_HW          = 8;
  localparam int DEF_SHIFT       = 2;
  localparam int DEF_HOLD_FRAMES = 30;
  localparam int DEF_DECAY_STEP  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_EMIT = 2'd2
  } state_e;

  // Width of a band index; never zero, even for a single-band bank.
  function automatic int band_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/meter_peak_hold.sv
// Peak-hold with timed decay for a single band.
// Ports:
//  clk, reset  clock and asynchronous active-low reset
//  lvl         scaled level of the band being loaded
//  load        this band is loaded into the output regs this cycle
//  frame_tick  one pulse per display frame; advances hold / decay
//  peak        current peak-hold value
module meter_peak_hold
  import meter_pkg::*;
#(
  parameter int HW          = DEF_HW,
  parameter int HOLD_FRAMES = DEF_HOLD_FRAMES,
  parameter int DECAY_STEP  = DEF_DECAY_STEP
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [HW-1:0] lvl,
  input  logic          load,
  input  logic          frame_tick,
  output logic [HW-1:0] peak
);

  localparam int CW = $clog2(HOLD_FRAMES + 1);

  logic [HW-1:0] peak_q, peak_d;
  logic [CW-1:0] hold_q, hold_d;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      peak_q <= '0;
      hold_q <= '0;
    end else begin
      peak_q <= peak_d;
      hold_q <= hold_d;
    end
  end

  // A load on the same cycle as a frame_tick takes priority; the tick is
  // dropped for this band only.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs (no latches).
    peak_d = peak_q;
    hold_d = hold_q;
    if (load) begin
      if (lvl >= peak_q) begin
        peak_d = lvl;
        hold_d = CW'(HOLD_FRAMES);
      end
    end else if (frame_tick) begin
      if (hold_q != '0) begin
        hold_d = hold_q - CW'(1);
      end else begin
        peak_d = (peak_q > HW'(DECAY_STEP)) ? peak_q - HW'(DECAY_STEP) : '0;
      end
    end
  end

  assign peak = peak_q;

endmodule

// File: rtl/band_meter_sequencer.sv
// Snapshots the filter bank's band powers on each power-window update, scales
// each band to a bar level, maintains per-band peak-hold, and streams one
// {band, level, peak} beat per band to the renderer over valid/ready.
// Ports:
//  clk, reset     clock and asynchronous active-low reset
//  enable         gates acceptance of power_update while idle
//  power_bus      band b power at [b*PW +: PW]
//  power_update   strobe: new power window complete
//  frame_tick     strobe per display frame (hold/decay timing)
//  out_valid/out_ready            beat handshake
//  out_band/out_level/out_peak    beat payload; out_last marks the final band
//  busy           sequencer not idle
//  overrun        pulse: an update was dropped because the sequencer was busy
module band_meter_sequencer
  import meter_pkg::*;
#(
  parameter int NUM_BANDS   = DEF_NUM_BANDS,
  parameter int PW          = DEF_PW,
  parameter int HW          = DEF_HW,
  parameter int SHIFT       = DEF_SHIFT,
  parameter int HOLD_FRAMES = DEF_HOLD_FRAMES,
  parameter int DECAY_STEP  = DEF_DECAY_STEP
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [NUM_BANDS*PW-1:0]       power_bus,
  input  logic                          power_update,
  input  logic                          frame_tick,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [band_w(NUM_BANDS)-1:0]  out_band,
  output logic [HW-1:0]                 out_level,
  output logic [HW-1:0]                 out_peak,
  output logic                          out_last,
  output logic                          busy,
  output logic                          overrun
);

  localparam int BW      = band_w(NUM_BANDS);
  localparam int LVL_MAX = (2 ** HW) - 1;

  state_e        state_q, state_d;
  logic [PW-1:0] snap_q [NUM_BANDS];
  logic [BW-1:0] idx_q;     // band currently held in the output regs

  logic          out_valid_q, out_last_q, overrun_q;
  logic [BW-1:0] out_band_q;
  logic [HW-1:0] out_level_q, out_peak_q;

  logic          accept, load_en, handshake, at_last;
  logic [BW-1:0] load_idx;
  logic [PW-1:0] load_shr;
  logic [HW-1:0] load_lvl, load_peak;
  logic [HW-1:0] peak_w [NUM_BANDS];

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (power_update && enable) state_d = ST_LOAD;
      ST_LOAD: state_d = ST_EMIT;
      ST_EMIT: if (handshake && at_last) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs / control ----------------
  always_comb begin
    busy      = (state_q != ST_IDLE);
    handshake = out_valid_q && out_ready;
    at_last   = (idx_q == BW'(NUM_BANDS - 1));
    accept    = (state_q == ST_IDLE) && power_update && enable;
    // LOAD presents band 0; each accepted non-final beat presents the next band.
    load_en   = (state_q == ST_LOAD) || ((state_q == ST_EMIT) && handshake && !at_last);
    load_idx  = (state_q == ST_LOAD) ? idx_q : idx_q + BW'(1);
  end

  // ---------------- scaler and peak merge for the band being loaded ----------------
  always_comb begin
    load_shr  = snap_q[load_idx] >> SHIFT;
    load_lvl  = (load_shr > PW'(LVL_MAX)) ? HW'(LVL_MAX) : load_shr[HW-1:0];
    // The beat reports the peak as it will be after this load.
    load_peak = (load_lvl >= peak_w[load_idx]) ? load_lvl : peak_w[load_idx];
  end

  for (genvar b = 0; b < NUM_BANDS; b++) begin : g_band
    meter_peak_hold #(
      .HW          (HW),
      .HOLD_FRAMES (HOLD_FRAMES),
      .DECAY_STEP  (DECAY_STEP)
    ) u_peak (
      .clk        (clk),
      .reset      (reset),
      .lvl        (load_lvl),
      .load       (load_en && (load_idx == BW'(b))),
      .frame_tick (frame_tick),
      .peak       (peak_w[b])
    );
  end

  // ---------------- snapshot and output registers ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the snapshot array is small, so it is reset like everything else;
      // no X can reach the scaler even if a load ever read a stale entry.
      for (int b = 0; b < NUM_BANDS; b++) snap_q[b] <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_band_q  <= '0;
      out_level_q <= '0;
      out_peak_q  <= '0;
      overrun_q   <= 1'b0;
    end else begin
      // Includes the final-handshake edge: state is still EMIT, so it drops.
      overrun_q <= power_update && busy;
      if (accept) begin
        for (int b = 0; b < NUM_BANDS; b++) snap_q[b] <= power_bus[b*PW +: PW];
        idx_q <= '0;
      end
      if (load_en) begin
        idx_q       <= load_idx;
        out_valid_q <= 1'b1;
        out_band_q  <= load_idx;
        out_level_q <= load_lvl;
        out_peak_q  <= load_peak;
        out_last_q  <= (load_idx == BW'(NUM_BANDS - 1));
      end else if (handshake && at_last) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_band  = out_band_q;
  assign out_level = out_level_q;
  assign out_peak  = out_peak_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_band_meter_sequencer.sv
// Self-checking bench for band_meter_sequencer: expected beats are produced by
// a behavioural level/peak model and queued at stimulus time, then compared
// against every valid beat the DUT presents.
module tb_band_meter_sequencer;
  import meter_pkg::*;

  localparam int NB = 7;
  localparam int PW = 11;
  localparam int HW = 8;

  logic              clk, reset, enable, power_update, frame_tick, out_ready;
  logic [NB*PW-1:0]  power_bus;
  logic              out_valid, out_last, busy, overrun;
  logic [2:0]        out_band;
  logic [HW-1:0]     out_level, out_peak;

  band_meter_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .power_bus    (power_bus),
    .power_update (power_update),
    .frame_tick   (frame_tick),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_band     (out_band),
    .out_level    (out_level),
    .out_peak     (out_peak),
    .out_last     (out_last),
    .busy         (busy),
    .overrun      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- model and scoreboard ----------------
  typedef struct {
    int band;
    int level;
    int peak;
    bit last;
  } beat_t;

  beat_t sb[$];
  int    mpeak[NB];
  int    mhold[NB];
  int    obs_level[NB];
  int    obs_peak[NB];
  int    beats_seen = 0;
  int    lasts_seen = 0;

  function automatic int lvl_of(input int p);
    int s;
    s = p >> 2;
    return (s > 255) ? 255 : s;
  endfunction

  task automatic model_tick(input int b);
    if (mhold[b] > 0) mhold[b]--;
    else mpeak[b] = (mpeak[b] > 4) ? mpeak[b] - 4 : 0;
  endtask

  task automatic model_clear();
    for (int b = 0; b < NB; b++) begin
      mpeak[b] = 0;
      mhold[b] = 0;
    end
  endtask

  // Monitor: compare every presented beat against the queue head (this also
  // verifies a stalled beat stays stable); pop once the handshake is certain.
  always begin
    @(negedge clk);
    if (out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_beat", 32'd1, 32'd0);
      end else begin
        check("beat_band",  32'(out_band),  sb[0].band);
        check("beat_level", 32'(out_level), sb[0].level);
        check("beat_peak",  32'(out_peak),  sb[0].peak);
        check("beat_last",  32'(out_last),  32'(sb[0].last));
      end
    end
    #2;
    if (out_valid === 1'b1 && out_ready === 1'b1 && sb.size() > 0) begin
      obs_level[out_band] = int'(out_level);
      obs_peak[out_band]  = int'(out_peak);
      beats_seen++;
      if (out_last) lasts_seen++;
      void'(sb.pop_front());
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive_frame(input int pw[NB], input bit tick_on_load, input bit chk_latency);
    int l;
    @(negedge clk);
    for (int b = 0; b < NB; b++) power_bus[b*PW +: PW] = PW'(pw[b]);
    power_update = 1'b1;
    // A tick on the band-0 load edge reaches bands 1..N-1 before they load.
    if (tick_on_load) for (int b = 1; b < NB; b++) model_tick(b);
    for (int b = 0; b < NB; b++) begin
      l = lvl_of(pw[b]);
      if (l >= mpeak[b]) begin
        mpeak[b] = l;
        mhold[b] = 30;
      end
      sb.push_back('{band: b, level: l, peak: mpeak[b], last: (b == NB - 1)});
    end
    @(negedge clk);
    power_update = 1'b0;
    frame_tick   = tick_on_load;
    if (chk_latency) begin
      check("lat_valid_T", 32'(out_valid), 32'd0);
      check("lat_busy_T",  32'(busy),      32'd1);
    end
    @(negedge clk);
    frame_tick = 1'b0;
    if (chk_latency) check("lat_valid_T1", 32'(out_valid), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy && sb.size() == 0) break;
    end
    check({tag, "_busy"},  32'(busy),      32'd0);
    check({tag, "_drain"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic tick_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      frame_tick = 1'b1;
      for (int b = 0; b < NB; b++) model_tick(b);
      @(negedge clk);
      frame_tick = 1'b0;
    end
  endtask

  task automatic wait_beat(input string tag, input int band, input bit want_last);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid && (want_last ? out_last : (int'(out_band) == band))) begin
        found = 1'b1;
        break;
      end
    end
    check({tag, "_found"}, 32'(found), 32'd1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"},   32'(out_valid), 32'd0);
    check({tag, "_band"},    32'(out_band),  32'd0);
    check({tag, "_level"},   32'(out_level), 32'd0);
    check({tag, "_peak"},    32'(out_peak),  32'd0);
    check({tag, "_last"},    32'(out_last),  32'd0);
    check({tag, "_busy"},    32'(busy),      32'd0);
    check({tag, "_overrun"}, 32'(overrun),   32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (elapsed %0t, limit 500000)", $time);
    $fatal(1);
  end

  // ---------------- test sequence ----------------
  initial begin
    int pw_ramp[NB];
    int pw_zero[NB];
    int pw_sat[NB];
    int pw_800[NB];
    int b0, l0;

    for (int b = 0; b < NB; b++) begin
      pw_ramp[b] = 4 * b;
      pw_zero[b] = 0;
      pw_sat[b]  = (b == 3) ? 2047 : 0;
      pw_800[b]  = (b == 0) ? 800 : 0;
    end
    model_clear();

    reset = 1'b1; enable = 1'b1; power_update = 1'b0; frame_tick = 1'b0;
    out_ready = 1'b1; power_bus = '0;
    #1 reset = 1'b0;
    #10 check_outputs_zero("rst");
    @(negedge clk) reset = 1'b1;

    // Ramp powers, ready held high: latency, 7 beats, single out_last.
    b0 = beats_seen; l0 = lasts_seen;
    drive_frame(pw_ramp, 1'b0, 1'b1);
    wait_idle("t2");
    check("t2_beats", 32'(beats_seen - b0), 32'd7);
    check("t2_lasts", 32'(lasts_seen - l0), 32'd1);
    check("t2_lvl6",  32'(obs_level[6]),   32'd6);

    // Same frame with a 5-cycle stall on band 2.
    b0 = beats_seen;
    drive_frame(pw_ramp, 1'b0, 1'b0);
    wait_beat("t3_band2", 2, 1'b0);
    #1 out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_stall_valid", 32'(out_valid), 32'd1);
      check("t3_stall_band",  32'(out_band),  32'd2);
    end
    #1 out_ready = 1'b1;
    wait_idle("t3");
    check("t3_beats", 32'(beats_seen - b0), 32'd7);

    // Saturation on band 3.
    drive_frame(pw_sat, 1'b0, 1'b0);
    wait_idle("t4");
    check("t4_level_sat", 32'(obs_level[3]), 32'd255);
    check("t4_peak_sat",  32'(obs_peak[3]),  32'd255);

    // Peak hold and decay on band 0, with a tick coincident with its load.
    drive_frame(pw_800, 1'b0, 1'b0);
    wait_idle("t5a");
    check("t5_peak_new", 32'(obs_peak[0]), 32'd200);
    tick_idle(30);
    drive_frame(pw_zero, 1'b0, 1'b0);
    wait_idle("t5b");
    check("t5_held_30", 32'(obs_peak[0]), 32'd200);
    tick_idle(1);
    drive_frame(pw_zero, 1'b0, 1'b0);
    wait_idle("t5c");
    check("t5_decay_31", 32'(obs_peak[0]), 32'd196);
    drive_frame(pw_zero, 1'b1, 1'b0);
    wait_idle("t6_tick");
    check("t6_tick_on_load", 32'(obs_peak[0]), 32'd196);
    tick_idle(49);
    drive_frame(pw_zero, 1'b0, 1'b0);
    wait_idle("t5d");
    check("t5_zero_80", 32'(obs_peak[0]), 32'd0);
    tick_idle(10);
    drive_frame(pw_zero, 1'b0, 1'b0);
    wait_idle("t5e");
    check("t5_no_underflow", 32'(obs_peak[0]), 32'd0);

    // Update while busy: dropped with a one-cycle overrun; frame unaffected.
    drive_frame(pw_ramp, 1'b0, 1'b0);
    @(negedge clk);
    power_bus = {NB{11'h7ff}};
    power_update = 1'b1;
    @(negedge clk);
    power_update = 1'b0;
    check("t6_overrun_pulse", 32'(overrun), 32'd1);
    @(negedge clk);
    check("t6_overrun_clear", 32'(overrun), 32'd0);
    // Update on the final handshake edge is also dropped.
    wait_beat("t6_last", 0, 1'b1);
    power_update = 1'b1;
    @(negedge clk);
    power_update = 1'b0;
    check("t6_final_overrun", 32'(overrun), 32'd1);
    check("t6_final_idle",    32'(busy),    32'd0);
    repeat (3) @(negedge clk);
    check("t6_not_accepted", 32'(busy), 32'd0);
    wait_idle("t6");

    // enable low in IDLE: update ignored without overrun.
    @(negedge clk);
    enable = 1'b0;
    power_update = 1'b1;
    @(negedge clk);
    power_update = 1'b0;
    check("en_ignored_busy",    32'(busy),    32'd0);
    check("en_ignored_overrun", 32'(overrun), 32'd0);
    enable = 1'b1;

    // Reset asserted mid-EMIT: outputs clear asynchronously, peaks restart.
    drive_frame(pw_ramp, 1'b0, 1'b0);
    wait_beat("t1_band3", 3, 1'b0);
    #1 reset = 1'b0;
    #1 check_outputs_zero("t1_async");
    sb.delete();
    model_clear();
    @(negedge clk) reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t1_no_resume", 32'(out_valid), 32'd0);
    end
    l0 = lasts_seen;
    drive_frame(pw_zero, 1'b0, 1'b0);
    wait_idle("t1");
    check("t1_peak2", 32'(obs_peak[2]), 32'd0);
    check("t1_peak6", 32'(obs_peak[6]), 32'd0);
    check("t1_lasts", 32'(lasts_seen - l0), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
